unidade_logica_n: RTL
=====================

# unidade_logica_n

Parametrised, registered bitwise logic unit. It extends the single-bit combinational AND gate to LARGURA-bit operands, eight selectable logic operations and a valid/ready handshake on both sides. Results are buffered in a small output FIFO so the producer can keep issuing while the consumer stalls. It sits in the Nrisc datapath as the logic half of the execute stage, beside the adder.

## Interface
- LARGURA, 8: operand and result width in bits (≥1).
- PROFUNDIDADE, 2: output FIFO depth in entries (power of two, ≥2).
- clock  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- entrada_valida  input  1  operands and opcode are presented.
- entrada_pronta  output  1  unit accepts an operation this cycle.
- operacao  input  3  opcode (see Operation).
- entrada1  input  LARGURA  operand A.
- entrada2  input  LARGURA  operand B.
- saida_valida  output  1  head FIFO entry is valid.
- saida_pronta  input  1  consumer takes the head entry this cycle.
- saida  output  LARGURA  result at the FIFO head.
- flag_zero  output  1  head result equals zero.
- contagem_ops  output  32  accepted-operation count (only with UNIDADE_LOGICA_CONTADOR_EN).

## Operation
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT entrada1
  - 111 pass entrada2
- Accept: entrada_valida && entrada_pronta at a rising edge. The result is computed combinationally from that cycle's inputs and written into the FIFO together with its zero flag.
- Release: saida_valida && saida_pronta at a rising edge pops the head.
- The FIFO has read pointer, write pointer and an occupancy counter `ocupacao` (0..PROFUNDIDADE). Pointers wrap modulo PROFUNDIDADE.
- entrada_pronta = (ocupacao != PROFUNDIDADE). It is registered-state-only, with no combinational path from saida_pronta.
  - When full, a pop in the same cycle does not enable a push; the push is accepted the next cycle.
- saida_valida = (ocupacao != 0). saida and flag_zero reflect the head entry directly, with no extra register stage.
- Simultaneous push and pop with 0 < ocupacao < PROFUNDIDADE: ocupacao unchanged, both pointers advance.
- Producer rule: must hold operacao, entrada1 and entrada2 stable while entrada_valida is high and entrada_pronta is low.
- Consumer rule: saida and flag_zero are stable while saida_valida is high and saida_pronta is low.

## Timing
- Reset (resetn low, asynchronous):
  - ocupacao = 0, both pointers = 0.
  - entrada_pronta = 1, saida_valida = 0, saida = 0, flag_zero = 0.
  - contagem_ops = 0.
- Reset mid-operation: all buffered results are discarded. No saida_valida until a new accept occurs after reset release.
- Latency: an operation accepted at edge N into an empty FIFO shows saida_valida = 1 with its result during cycle N+1.
- Throughput: one operation per cycle while saida_pronta stays high.
- Full: after PROFUNDIDADE accepts with no pop, entrada_pronta is 0 from the following cycle.
- FIFO storage contents are not reset; they are only visible through saida while saida_valida is high.

## Configuration
- UNIDADE_LOGICA_CONTADOR_EN defined:
  - Adds port contagem_ops, a 32-bit register that increments by 1 on every accept.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset to 0.
- Not defined: port and register are absent. All other behaviour is identical.

## Structure
- Package unidade_logica_pkg holds:
  - opcode constants OP_AND … OP_PASS_B (3-bit);
  - the opcode typedef;
  - the function computing the result from opcode and operands.
- Sub-module fila_saida, parametrised on width (LARGURA+1, result plus zero flag) and PROFUNDIDADE. It owns the pointers, ocupacao and the full/empty logic.
- The top level holds the opcode decode and the optional counter.

## Test plan
- Reset, then one op per opcode with LARGURA=8, entrada1=0xF0, entrada2=0x3C, saida_pronta=1. Required results, one cycle after each accept:
  - 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, 0x0F, 0x3C.
  - flag_zero = 0 for all.
- AND 0xF0 & 0x0F → saida 0x00, flag_zero 1.
- saida_pronta=0, issue 3 ops back-to-back (PROFUNDIDADE=2):
  - first two accepted;
  - entrada_pronta 0 from the 3rd cycle;
  - the 3rd op is held.
  - Then raise saida_pronta: outputs appear in issue order, and the 3rd op is accepted the cycle after the first pop.
- Streaming: 7 ops with saida_pronta toggling every cycle → all 7 results are in order with none lost or duplicated, and the pointers wrap at least 3 times.
- Assert resetn low with 2 entries buffered → saida_valida 0 immediately; after release, the first new accept appears at N+1.
- With UNIDADE_LOGICA_CONTADOR_EN: 5 accepts → contagem_ops = 5. Stalled cycles (valid high, pronta low) do not count.

Source files
------------

// File: rtl/unidade_logica_pkg.sv
// Opcode encoding and per-bit result function for the Nrisc logic unit.
// Shared by unidade_logica_n and its bench.
package unidade_logica_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_XOR    = 3'b010,
        OP_NAND   = 3'b011,
        OP_NOR    = 3'b100,
        OP_XNOR   = 3'b101,
        OP_NOT_A  = 3'b110,
        OP_PASS_B = 3'b111
    } opcode_t;

    // Single-bit slice of the operation; the top replicates it across LARGURA,
    // so the width is unbounded and no truncation is needed.
    function automatic logic calcula_bit(input opcode_t op, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XNOR:   r = ~(a ^ b);
            OP_NOT_A:  r = ~a;
            OP_PASS_B: r = b;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/unidade_logica_n_fila_saida.sv
// Output FIFO of the logic unit: storage, read/write pointers and occupancy.
// Head data reads as zero while empty, so stale storage never leaks out.
module fila_saida #(
    parameter int LARGURA      = 9,
    parameter int PROFUNDIDADE = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               escrita,
    input  logic [LARGURA-1:0] dado_escrita,
    input  logic               leitura,
    output logic [LARGURA-1:0] dado_leitura,
    output logic               cheia,
    output logic               vazia
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int OW = $clog2(PROFUNDIDADE + 1);

    logic [PW-1:0]      ptr_escrita;
    logic [PW-1:0]      ptr_leitura;
    logic [OW-1:0]      ocupacao;
    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic               push;
    logic               pop;

    // Full is decided from registered occupancy only: a pop in the same
    // cycle never frees a slot for a push.
    assign cheia = (ocupacao == OW'(PROFUNDIDADE));
    assign vazia = (ocupacao == '0);
    assign push  = escrita && !cheia;
    assign pop   = leitura && !vazia;

    assign dado_leitura = vazia ? '0 : mem[ptr_leitura];

    always_ff @(posedge clock) begin
        if (push) mem[ptr_escrita] <= dado_escrita;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_escrita <= '0;
            ptr_leitura <= '0;
            ocupacao    <= '0;
        end else begin
            if (push) ptr_escrita <= ptr_escrita + 1'b1;
            if (pop)  ptr_leitura <= ptr_leitura + 1'b1;
            case ({push, pop})
                2'b10:   ocupacao <= ocupacao + 1'b1;
                2'b01:   ocupacao <= ocupacao - 1'b1;
                default: ocupacao <= ocupacao;
            endcase
        end
    end

endmodule

// File: rtl/unidade_logica_n.sv
// Registered LARGURA-bit logic unit with valid/ready handshakes and output FIFO.
// Define UNIDADE_LOGICA_CONTADOR_EN to add the contagem_ops accept counter.
module unidade_logica_n
    import unidade_logica_pkg::*;
#(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               entrada_valida,
    output logic               entrada_pronta,
    input  logic [2:0]         operacao,
    input  logic [LARGURA-1:0] entrada1,
    input  logic [LARGURA-1:0] entrada2,
    output logic               saida_valida,
    input  logic               saida_pronta,
    output logic [LARGURA-1:0] saida,
    output logic               flag_zero
`ifdef UNIDADE_LOGICA_CONTADOR_EN
    ,
    output logic [31:0]        contagem_ops
`endif
);

    opcode_t            op;
    logic [LARGURA-1:0] resultado;
    logic [LARGURA:0]   entrada_fila;
    logic [LARGURA:0]   cabeca;
    logic               cheia;
    logic               vazia;
    logic               aceito;

    assign op = opcode_t'(operacao);

    for (genvar i = 0; i < LARGURA; i++) begin : gen_bit
        assign resultado[i] = calcula_bit(op, entrada1[i], entrada2[i]);
    end

    assign entrada_fila = {~|resultado, resultado};

    assign entrada_pronta = ~cheia;
    assign saida_valida   = ~vazia;
    assign aceito         = entrada_valida && entrada_pronta;
    assign {flag_zero, saida} = cabeca;

    fila_saida #(
        .LARGURA     (LARGURA + 1),
        .PROFUNDIDADE(PROFUNDIDADE)
    ) u_fila (
        .clock       (clock),
        .resetn      (resetn),
        .escrita     (aceito),
        .dado_escrita(entrada_fila),
        .leitura     (saida_pronta),
        .dado_leitura(cabeca),
        .cheia       (cheia),
        .vazia       (vazia)
    );

`ifdef UNIDADE_LOGICA_CONTADOR_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     contagem_ops <= '0;
        else if (aceito) contagem_ops <= contagem_ops + 32'd1;
    end
`endif

endmodule
